// File: rtl/calc_pkg.sv
// Shared encodings and constants for the BCD keypad calculator.
package calc_pkg;

  // Keypad command encodings; 0-9 are plain digits
  typedef enum logic [3:0] {
    CMD_ADD = 4'hA,
    CMD_SUB = 4'hB,
    CMD_MUL = 4'hC,
    CMD_CE  = 4'hD,
    CMD_EQ  = 4'hE,
    CMD_BS  = 4'hF
  } cmd_e;

  typedef enum logic [1:0] {
    ST_EDIT  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_SHOW  = 2'b10,
    ST_ERROR = 2'b11
  } status_e;

  // Controller states kept as plain constants for older tool flows
  typedef logic [2:0] state_e;
  localparam state_e S_EDIT_A = 3'd0;
  localparam state_e S_EDIT_B = 3'd1;
  localparam state_e S_LOAD   = 3'd2;
  localparam state_e S_EXEC   = 3'd3;
  localparam state_e S_DABBLE = 3'd4;
  localparam state_e S_DISP   = 3'd5;
  localparam state_e S_SHOW   = 3'd6;
  localparam state_e S_ERROR  = 3'd7;

  // Active-low segments {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'h06;

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Bits needed to hold any n-digit decimal magnitude
  function automatic int mag_width(input int n);
    longint p;
    int     w;
    p = pow10(n);
    w = 0;
    for (int i = 0; i < 63; i++)
      if ((longint'(1) << i) < p) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/calc_core_n_seg7.sv
// Combinational BCD digit to active-low seven-segment pattern, with blanking.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Segment lookup; non-decimal codes and blanked digits show nothing
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0: o_seg = 7'h40;
        4'd1: o_seg = 7'h79;
        4'd2: o_seg = 7'h24;
        4'd3: o_seg = 7'h30;
        4'd4: o_seg = 7'h19;
        4'd5: o_seg = 7'h12;
        4'd6: o_seg = 7'h02;
        4'd7: o_seg = 7'h78;
        4'd8: o_seg = 7'h00;
        4'd9: o_seg = 7'h10;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/calc_core_n.sv
// NDIGITS-digit keypad calculator: BCD entry, serial BCD->binary load,
// shift-add multiply, double-dabble back to BCD, signed result display.
module calc_core_n
  import calc_pkg::*;
#(
  parameter int NDIGITS = 8,
  parameter int W       = mag_width(NDIGITS)
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [3:0]              i_cmd,
  input  logic                    i_cmd_valid,
  output logic [NDIGITS-1:0][6:0] o_displays,
  output logic [1:0]              o_status
);

  localparam int             BW      = 4 * NDIGITS;
  localparam int             CW      = $clog2(W + 1);
  localparam logic [W-1:0]   TEN     = W'(10);
  localparam logic [2*W-1:0] MAX_POS = (2*W)'(pow10(NDIGITS) - 1);
  localparam logic [2*W-1:0] MAX_NEG = (2*W)'(pow10(NDIGITS - 1) - 1);

  state_e              r_state;
  logic [CW-1:0]       r_cnt;     // shared LOAD / multiply / dabble step counter
  logic [BW-1:0]       r_entry;   // BCD entry; doubles as LOAD shift source
  logic signed [W:0]   r_a;
  logic [W-1:0]        r_b;       // B during LOAD, multiplier during EXEC
  logic [3:0]          r_op;
  logic                r_hold;    // keep showing A until first B digit
  logic [2*W-1:0]      r_mcand;
  logic [2*W-1:0]      r_mag;     // product accumulator, then dabble source
  logic                r_neg;
  logic signed [W:0]   r_res;     // last result, reused as A when chaining
  logic [BW-1:0]       r_dd;
  logic [BW-1:0]       r_dbcd;
  logic                r_dneg;

  logic                      w_is_digit, w_is_op, w_full, w_is_mul;
  logic [W-1:0]              w_entry_bin, w_a_mag;
  logic signed [W+1:0]       w_sum;
  logic [W+1:0]              w_sum_mag;
  logic [2*W-1:0]            w_prod_nxt, w_fin_mag;
  logic                      w_fin_neg, w_ovf, w_exec_done;
  logic signed [W:0]         w_fin_res;
  logic [BW-1:0]             w_dd_adj, w_src;
  logic                      w_use_entry, w_neg;
  logic [NDIGITS-1:0]        w_blank;
  logic [NDIGITS-1:0][6:0]   w_seg;

  assign w_is_digit = (i_cmd <= 4'd9);
  assign w_is_op    = (i_cmd == CMD_ADD) || (i_cmd == CMD_SUB) || (i_cmd == CMD_MUL);
  assign w_full     = (r_entry[BW-1 -: 4] != 4'd0);
  assign w_is_mul   = (r_op == CMD_MUL);

  // Entry as binary, used when A is latched straight from the keypad
  always_comb begin
    w_entry_bin = '0;
    for (int i = NDIGITS - 1; i >= 0; i--)
      w_entry_bin = w_entry_bin * TEN + W'(r_entry[4*i +: 4]);
  end

  assign w_a_mag    = r_a[W] ? W'(-r_a) : r_a[W-1:0];
  assign w_sum      = (r_op == CMD_SUB) ? ($signed({r_a[W], r_a}) - $signed({2'b00, r_b}))
                                        : ($signed({r_a[W], r_a}) + $signed({2'b00, r_b}));
  assign w_sum_mag  = w_sum[W+1] ? $unsigned(-w_sum) : $unsigned(w_sum);
  assign w_prod_nxt = r_b[0] ? (r_mag + r_mcand) : r_mag;

  // B is never negative, so the product takes A's sign; zero is never negative
  assign w_fin_mag   = w_is_mul ? w_prod_nxt : (2*W)'(w_sum_mag);
  assign w_fin_neg   = (w_is_mul ? r_a[W] : w_sum[W+1]) && (w_fin_mag != '0);
  assign w_ovf       = w_fin_neg ? (w_fin_mag > MAX_NEG) : (w_fin_mag > MAX_POS);
  assign w_exec_done = !w_is_mul || (r_cnt == CW'(W - 1));
  assign w_fin_res   = w_fin_neg ? -$signed({1'b0, w_fin_mag[W-1:0]})
                                 :  $signed({1'b0, w_fin_mag[W-1:0]});

  // Double-dabble correction: add 3 to every BCD digit of 5 or more
  always_comb begin
    w_dd_adj = r_dd;
    for (int i = 0; i < NDIGITS; i++)
      if (r_dd[4*i +: 4] >= 4'd5) w_dd_adj[4*i +: 4] = r_dd[4*i +: 4] + 4'd3;
  end

  // Controller: keypad editing, LOAD / EXEC / DABBLE sequencing, result latch
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= S_EDIT_A;  r_cnt  <= '0;  r_entry <= '0;   r_a     <= '0;
      r_b     <= '0;        r_op   <= CMD_ADD;              r_hold  <= 1'b0;
      r_mcand <= '0;        r_mag  <= '0;  r_neg   <= 1'b0; r_res   <= '0;
      r_dd    <= '0;        r_dbcd <= '0;  r_dneg  <= 1'b0;
    end else begin
      case (r_state)
        S_EDIT_A, S_EDIT_B: if (i_cmd_valid) begin
          if (w_is_digit) begin
            if (!w_full) begin
              r_entry <= {r_entry[BW-5:0], i_cmd};
              r_hold  <= 1'b0;
            end
          end else if (w_is_op) begin
            r_op <= i_cmd;
            if (r_state == S_EDIT_A) begin
              r_a     <= $signed({1'b0, w_entry_bin});
              r_dbcd  <= r_entry;
              r_dneg  <= 1'b0;
              r_entry <= '0;
              r_hold  <= 1'b1;
              r_state <= S_EDIT_B;
            end
          end else if (i_cmd == CMD_CE) begin
            r_entry <= '0;
          end else if (i_cmd == CMD_BS) begin
            r_entry <= {4'd0, r_entry[BW-1:4]};
          end else begin
            // '=' with no second operand evaluates A + 0
            if (r_state == S_EDIT_A) begin
              r_a     <= $signed({1'b0, w_entry_bin});
              r_op    <= CMD_ADD;
              r_entry <= '0;
            end
            r_b     <= '0;
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_b     <= r_b * TEN + W'(r_entry[BW-1 -: 4]);
          r_entry <= {r_entry[BW-5:0], 4'd0};
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(NDIGITS - 1)) begin
            r_cnt   <= '0;
            r_mag   <= '0;
            r_mcand <= (2*W)'(w_a_mag);
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_mul) begin
            r_mag   <= w_prod_nxt;
            r_mcand <= r_mcand << 1;
            r_b     <= r_b >> 1;
            r_cnt   <= r_cnt + 1'b1;
          end
          if (w_exec_done) begin
            r_cnt   <= '0;
            r_mag   <= w_fin_mag;
            r_neg   <= w_fin_neg;
            r_res   <= w_fin_res;
            r_dd    <= '0;
            r_state <= w_ovf ? S_ERROR : S_DABBLE;
          end
        end
        S_DABBLE: begin
          r_dd  <= {w_dd_adj[BW-2:0], r_mag[W-1]};
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W - 1)) r_state <= S_DISP;
        end
        S_DISP: begin
          r_dbcd  <= r_dd;
          r_dneg  <= r_neg;
          r_state <= S_SHOW;
        end
        S_SHOW: if (i_cmd_valid) begin
          if (w_is_digit) begin
            r_entry <= BW'(i_cmd);
            r_hold  <= 1'b0;
            r_state <= S_EDIT_A;
          end else if (w_is_op) begin
            r_a     <= r_res;
            r_op    <= i_cmd;
            r_entry <= '0;
            r_hold  <= 1'b1;
            r_state <= S_EDIT_B;
          end else if (i_cmd == CMD_CE) begin
            r_entry <= '0;  r_a <= '0;  r_op <= CMD_ADD;
            r_hold  <= 1'b0; r_state <= S_EDIT_A;
          end
        end
        S_ERROR: if (i_cmd_valid && (i_cmd == CMD_CE)) begin
          r_entry <= '0;  r_a <= '0;  r_op <= CMD_ADD;
          r_hold  <= 1'b0; r_state <= S_EDIT_A;
        end
        default: r_state <= S_EDIT_A;
      endcase
    end
  end

  // Status code from controller state
  always_comb begin
    case (r_state)
      S_EDIT_A, S_EDIT_B: o_status = ST_EDIT;
      S_SHOW:             o_status = ST_SHOW;
      S_ERROR:            o_status = ST_ERROR;
      default:            o_status = ST_BUSY;
    endcase
  end

  assign w_use_entry = ((r_state == S_EDIT_A) || (r_state == S_EDIT_B)) && !r_hold;
  assign w_src       = w_use_entry ? r_entry : r_dbcd;
  assign w_neg       = !w_use_entry && r_dneg;

  // Leading-zero blanking: a digit is blank if it and everything above is zero
  always_comb begin
    w_blank = '0;
    w_blank[NDIGITS-1] = (w_src[BW-1 -: 4] == 4'd0);
    for (int i = NDIGITS - 2; i >= 0; i--)
      w_blank[i] = w_blank[i+1] && (w_src[4*i +: 4] == 4'd0);
    w_blank[0] = 1'b0;
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_dig
    seg7_decoder u_dec (
      .i_bcd   (w_src[4*g +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg[g])
    );
  end

  // Final display: minus sign just left of the MSD, ERROR overrides everything
  always_comb begin
    o_displays = w_seg;
    if (w_neg)
      for (int i = 1; i < NDIGITS; i++)
        if (w_blank[i] && !w_blank[i-1]) o_displays[i] = SEG_MINUS;
    if (r_state == S_ERROR) begin
      o_displays    = {NDIGITS{SEG_BLANK}};
      o_displays[0] = SEG_E;
    end
  end

endmodule

// File: tb/tb_calc_core_n.sv
// Directed and random keypad sequences against a decimal-arithmetic model.
module tb_calc_core_n;
  localparam int     N   = 8;
  localparam int     DW  = 7 * N;
  localparam longint LIM = 100000000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        cmd = 4'd0;
  logic              cmd_valid = 1'b0;
  logic [N-1:0][6:0] displays;
  logic [1:0]        status;

  calc_core_n #(.NDIGITS(N)) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_cmd       (cmd),
    .i_cmd_valid (cmd_valid),
    .o_displays  (displays),
    .o_status    (status)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Calculator model in plain decimal terms; mode 0 A-entry, 1 B-entry, 2 show, 3 error
  longint m_entry, m_a, m_shown;
  int     m_op, m_mode;
  bit     m_hold;

  task automatic model_clear();
    m_entry = 0; m_a = 0; m_shown = 0; m_op = 10; m_mode = 0; m_hold = 0;
  endtask

  task automatic model_key(input int k);
    longint b, r;
    if (m_mode == 3) begin
      if (k == 13) model_clear();
    end else if (m_mode == 2) begin
      if (k <= 9) begin m_entry = k; m_mode = 0; m_hold = 0; end
      else if (k >= 10 && k <= 12) begin
        m_a = m_shown; m_op = k; m_entry = 0; m_hold = 1; m_mode = 1;
      end else if (k == 13) model_clear();
    end else begin
      if (k <= 9) begin
        if (m_entry < LIM / 10) begin m_entry = m_entry * 10 + k; m_hold = 0; end
      end else if (k >= 10 && k <= 12) begin
        m_op = k;
        if (m_mode == 0) begin
          m_a = m_entry; m_shown = m_entry; m_entry = 0; m_hold = 1; m_mode = 1;
        end
      end else if (k == 13) m_entry = 0;
      else if (k == 15) m_entry = m_entry / 10;
      else begin
        if (m_mode == 0) begin m_a = m_entry; m_op = 10; b = 0; end
        else b = m_entry;
        r = (m_op == 10) ? m_a + b : (m_op == 11) ? m_a - b : m_a * b;
        m_entry = 0; m_hold = 0;
        if (r > LIM - 1 || r < -(LIM / 10 - 1)) m_mode = 3;
        else begin m_mode = 2; m_shown = r; end
      end
    end
  endtask

  function automatic logic [DW-1:0] render(input longint v);
    logic [DW-1:0] r;
    longint        m;
    int            nd;
    r  = {N{7'h7F}};
    m  = (v < 0) ? -v : v;
    nd = 0;
    if (m == 0) begin r[6:0] = seg_tab[0]; nd = 1; end
    while (m > 0) begin
      r[nd*7 +: 7] = seg_tab[int'(m % 10)];
      m = m / 10;
      nd++;
    end
    if (v < 0) r[nd*7 +: 7] = 7'b0111111;
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_disp();
    logic [DW-1:0] r;
    if (m_mode == 3) begin r = {N{7'h7F}}; r[6:0] = 7'h06; end
    else if (m_mode == 2 || m_hold) r = render(m_shown);
    else r = render(m_entry);
    return r;
  endfunction

  function automatic logic [1:0] exp_status();
    return (m_mode <= 1) ? 2'b00 : (m_mode == 2) ? 2'b10 : 2'b11;
  endfunction

  // One key strobe, BUSY-length check after '=', then status/display check
  task automatic press(input logic [3:0] k, input bit inject);
    int pre_mode, exp_busy, n;
    pre_mode = m_mode;
    exp_busy = (pre_mode == 1 && m_op == 12) ? 63 : 37;
    @(negedge clk); cmd = k; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    model_key(int'(k));
    if (k == 4'hE && pre_mode <= 1) begin
      n = 0;
      while (status == 2'b01 && n < 200) begin
        if (inject && n == 5) begin cmd = 4'd7; cmd_valid = 1'b1; end
        else cmd_valid = 1'b0;
        @(negedge clk);
        n++;
      end
      cmd_valid = 1'b0;
      if (m_mode == 2) chk("busy_cycles", 64'(n), 64'(exp_busy));
      else chk("busy_bound", 64'(n >= 200), 64'd0);
    end
    repeat (10) @(negedge clk);
    chk($sformatf("status key=%0h", k), 64'(status), 64'(exp_status()));
    chk($sformatf("displays key=%0h", k), 64'(displays), 64'(exp_disp()));
  endtask

  task automatic keys(input string s);
    logic [3:0] k;
    for (int i = 0; i < s.len(); i++) begin
      k = (s[i] >= "0" && s[i] <= "9") ? 4'(s[i] - "0") : 4'(s[i] - "A" + 10);
      press(k, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset_status", 64'(status), 64'(exp_status()));
    chk("reset_displays", 64'(displays), 64'(exp_disp()));
    rst_n = 1'b1;

    keys("123A1E");
    keys("50B15E");
    keys("D15B50E");
    keys("6C2");
    press(4'hE, 1'b1);
    keys("456F");
    keys("D123456789");
    keys("FFFFFFFFF");
    keys("D99999999C2E");
    keys("3D");
    keys("12A3E");
    keys("A5E");

    // Reset during a multiply, with a simultaneous key that must be ignored
    keys("6C2");
    @(negedge clk); cmd = 4'hE; cmd_valid = 1'b1;
    @(negedge clk); cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy", 64'(status), 64'd1);
    rst_n = 1'b0; cmd = 4'd5; cmd_valid = 1'b1;
    @(negedge clk); rst_n = 1'b1; cmd_valid = 1'b0;
    model_clear();
    chk("rst_abort_status", 64'(status), 64'(exp_status()));
    chk("rst_abort_displays", 64'(displays), 64'(exp_disp()));
    repeat (5) @(negedge clk);
    chk("rst_abort_hold", 64'(displays), 64'(exp_disp()));

    for (int i = 0; i < 120; i++) begin
      logic [3:0] k;
      k = ($urandom_range(0, 99) < 60) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      press(k, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
